// File: rtl/apb_node_pkg.sv
// rtl/apb_node_pkg.sv - shared types and constants for the registered APB node
package apb_node_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_node_state_e;

  // Read data returned on decode misses and timeouts
  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

  localparam int unsigned TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - start/end range address decoder, lowest index wins
module apb_addr_decoder #(
  parameter int NB_SLAVES  = 9,
  parameter int ADDR_WIDTH = 32,
  localparam int IDX_W     = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] start_addr,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] end_addr,
  output logic                            hit,
  output logic [IDX_W-1:0]                idx
);

  logic [ADDR_WIDTH-1:0] lo;
  logic [ADDR_WIDTH-1:0] hi;

  // Scan from the top index down so the lowest matching index is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    lo  = '0;
    hi  = '0;
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      lo = start_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      hi = end_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      // An inverted range (lo > hi) can never satisfy both bounds
      if ((addr >= lo) && (addr <= hi)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_node_reg.sv
// rtl/apb_node_reg.sv - registered APB 1-to-N node; APB_NODE_TIMEOUT_EN adds the access timeout
module apb_node_reg
  import apb_node_pkg::*;
#(
  parameter int NB_SLAVES      = 9,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = apb_node_pkg::TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] end_addr_i,
  input  logic [ADDR_WIDTH-1:0]           m_paddr,
  input  logic [DATA_WIDTH-1:0]           m_pwdata,
  input  logic                            m_pwrite,
  input  logic                            m_psel,
  input  logic                            m_penable,
  output logic [DATA_WIDTH-1:0]           m_prdata,
  output logic                            m_pready,
  output logic                            m_pslverr,
  output logic [ADDR_WIDTH-1:0]           s_paddr,
  output logic [DATA_WIDTH-1:0]           s_pwdata,
  output logic                            s_pwrite,
  output logic [NB_SLAVES-1:0]            s_psel,
  output logic                            s_penable,
  input  logic [NB_SLAVES*DATA_WIDTH-1:0] s_prdata,
  input  logic [NB_SLAVES-1:0]            s_pready,
  input  logic [NB_SLAVES-1:0]            s_pslverr
);

  localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);

  apb_node_state_e  state;
  logic [IDX_W-1:0] cur_idx;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;

`ifdef APB_NODE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  apb_addr_decoder #(
    .NB_SLAVES (NB_SLAVES),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_decoder (
    .addr      (m_paddr),
    .start_addr(start_addr_i),
    .end_addr  (end_addr_i),
    .hit       (dec_hit),
    .idx       (dec_idx)
  );

  // Setup/access sequencer; every output is a register so the core port is isolated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_idx   <= '0;
      s_paddr   <= '0;
      s_pwdata  <= '0;
      s_pwrite  <= 1'b0;
      s_psel    <= '0;
      s_penable <= 1'b0;
      m_prdata  <= '0;
      m_pready  <= 1'b0;
      m_pslverr <= 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m_psel && !m_penable) begin
            if (dec_hit) begin
              // Slave-side request only changes on a hit, so misses leave no trace
              s_paddr         <= m_paddr;
              s_pwdata        <= m_pwdata;
              s_pwrite        <= m_pwrite;
              s_psel          <= '0;
              s_psel[dec_idx] <= 1'b1;
              cur_idx         <= dec_idx;
              state           <= SETUP;
            end else begin
              m_prdata  <= ERR_DATA;
              m_pslverr <= 1'b1;
              m_pready  <= 1'b1;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          s_penable <= 1'b1;
`ifdef APB_NODE_TIMEOUT_EN
          to_cnt    <= '0;
`endif
          state     <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over a timeout landing in the same cycle
          if (s_pready[cur_idx]) begin
            m_prdata  <= s_prdata[DATA_WIDTH*cur_idx +: DATA_WIDTH];
            m_pslverr <= s_pslverr[cur_idx];
            m_pready  <= 1'b1;
            s_psel    <= '0;
            s_penable <= 1'b0;
            state     <= RESP;
          end
`ifdef APB_NODE_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            // Abort the slave mid-access; it must tolerate the select dropping
            m_prdata  <= ERR_DATA;
            m_pslverr <= 1'b1;
            m_pready  <= 1'b1;
            s_psel    <= '0;
            s_penable <= 1'b0;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          m_prdata  <= '0;
          m_pslverr <= 1'b0;
          m_pready  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
